// File: rtl/avr_serial_tx_if.sv
// Write-side bundle of the AVR serial transmitter: byte strobe in, FIFO status out.
interface avr_serial_tx_if;
  logic [7:0] data;
  logic       new_data;
  logic       busy;
  logic       overflow;

  modport master (
    output data,
    output new_data,
    input  busy,
    input  overflow
  );

  modport slave (
    input  data,
    input  new_data,
    output busy,
    output overflow
  );
endinterface

// File: rtl/avr_serial_tx.sv
// UART transmitter (8N1, LSB first) from the FPGA to the on-board AVR.
// Bytes are queued in a small FIFO; a frame only starts while the CCLK detector
// reports ready and the AVR is not asserting tx_block, so the AVR RX pin is never
// driven before the AVR has finished configuring the FPGA.
//
// state | meaning
// IDLE  | line high; wait for queued byte, ready and unblocked line
// START | start bit (low) for CLK_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLK_PER_BIT cycles each
// STOP  | stop bit (high) for CLK_PER_BIT cycles
module avr_serial_tx #(
  parameter int CLK_PER_BIT = 100,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ready,
  input  logic           tx_block,
  avr_serial_tx_if.slave wr,
  output logic           tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CTR_W = $clog2(CLK_PER_BIT);

  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic             tx_blk_m;
  logic             tx_blk_s;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             busy_q;
  logic             overflow_q;
  logic             push;
  logic             pop;
  logic [1:0]       state;
  logic [7:0]       shreg;
  logic [2:0]       bit_ctr;
  logic [CTR_W-1:0] clk_ctr;
  logic             bit_done;
  logic             tx_nxt;

  // busy is derived from the registered count, so it reflects the pre-edge fill level
  assign busy_q      = (count == CNT_FULL);
  assign wr.busy     = busy_q;
  assign wr.overflow = overflow_q;

  assign push     = wr.new_data & ~busy_q;
  assign pop      = (state == IDLE) & (count != '0) & ready & ~tx_blk_s;
  assign bit_done = (clk_ctr == CTR_LAST);

  // Two-flop synchroniser for the asynchronous AVR flow-control line; resets to blocked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_blk_m <= 1'b1;
      tx_blk_s <= 1'b1;
    end else begin
      tx_blk_m <= tx_block;
      tx_blk_s <= tx_blk_m;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr.data;
    end
  end

  // FIFO pointers, fill count and the registered overflow pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= wr.new_data & busy_q;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer; gating is only evaluated in IDLE so a frame is never cut short
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_ctr <= '0;
      clk_ctr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= mem[rd_ptr];
            bit_ctr <= '0;
            clk_ctr <= '0;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            clk_ctr <= '0;
            state   <= DATA;
          end else begin
            clk_ctr <= clk_ctr + CTR_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            clk_ctr <= '0;
            shreg   <= {1'b0, shreg[7:1]};
            bit_ctr <= bit_ctr + 3'd1;
            if (bit_ctr == 3'd7) begin
              state <= STOP;
            end
          end else begin
            clk_ctr <= clk_ctr + CTR_W'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            clk_ctr <= '0;
            state   <= IDLE;
          end else begin
            clk_ctr <= clk_ctr + CTR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line level implied by the current state
  always_comb begin
    tx_nxt = 1'b1;
    case (state)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  // Registered line driver; idles high and returns high immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx <= 1'b1;
    end else begin
      tx <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_avr_serial_tx.sv
// Self-checking bench for avr_serial_tx: directed scenarios plus a randomized phase,
// all checked cycle-by-cycle against a queue/arithmetic model of the UART line.
module tb_avr_serial_tx;

  localparam int CPB   = 100;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk;
  logic rst;
  logic ready;
  logic tx_block;
  logic tx;

  avr_serial_tx_if wr_if ();

  avr_serial_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .tx_block (tx_block),
    .wr       (wr_if),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The line is a pure function of the edge at which a byte left the FIFO:
  // after edge pop+1+k the line carries frame bit k/CPB of {stop, byte, start}.
  int         m_cyc;
  int         m_pop;
  bit         m_have;
  logic [7:0] m_q[$];
  logic [7:0] m_byte;
  logic [9:0] m_frame;
  logic       m_h0, m_h1;
  logic       m_blk_pre, m_idle_pre, m_full_pre;
  int         m_k;
  logic       exp_tx, exp_busy, exp_ovf;

  function automatic bit m_drained();
    return (m_q.size() == 0) && (!m_have || (m_cyc > m_pop + FRAME));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc    = 0;
      m_pop    = 0;
      m_have   = 0;
      m_q.delete();
      m_h0     = 1'b1;
      m_h1     = 1'b1;
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      m_cyc++;
      m_blk_pre  = m_h1;
      m_h1       = m_h0;
      m_h0       = tx_block;
      m_idle_pre = !m_have || (m_cyc > m_pop + FRAME);
      m_full_pre = (m_q.size() == DEPTH);
      exp_ovf    = wr_if.new_data && m_full_pre;
      if (m_idle_pre && m_q.size() != 0 && ready && !m_blk_pre) begin
        m_byte = m_q.pop_front();
        m_pop  = m_cyc;
        m_have = 1;
      end
      if (wr_if.new_data && !m_full_pre) m_q.push_back(wr_if.data);
      exp_busy = (m_q.size() == DEPTH);
      m_k      = m_cyc - (m_pop + 1);
      m_frame  = {1'b1, m_byte, 1'b0};
      if (m_have && m_k >= 0 && m_k < FRAME) exp_tx = m_frame[m_k / CPB];
      else                                   exp_tx = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("tx", tx, exp_tx);
      chk("busy", wr_if.busy, exp_busy);
      chk("overflow", wr_if.overflow, exp_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!m_drained() && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", m_drained(), 1'b1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [9:0] a5_frame;
  int         burst;

  initial begin
    rst            = 1'b1;
    ready          = 1'b0;
    tx_block       = 1'b1;
    wr_if.data     = 8'h00;
    wr_if.new_data = 1'b0;
    burst          = 0;
    tick(3);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", wr_if.busy, 1'b0);
    chk("rst_overflow", wr_if.overflow, 1'b0);
    rst = 1'b0;

    // 1: single byte 0xA5, latency and bit-by-bit line pattern
    ready    = 1'b1;
    tx_block = 1'b0;
    tick(3);
    wr_if.data     = 8'hA5;
    wr_if.new_data = 1'b1;
    @(negedge clk);
    wr_if.new_data = 1'b0;
    @(negedge clk);
    chk("lat_still_high", tx, 1'b1);
    @(negedge clk);
    chk("lat_start_low", tx, 1'b0);
    a5_frame = {1'b1, 8'hA5, 1'b0};
    tick(CPB / 2);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("a5_bit%0d", i), tx, a5_frame[i]);
      tick(CPB);
    end

    // 2: fill while not ready, overflow on fifth write, then release in order
    ready = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      wr_if.data     = 8'(b);
      wr_if.new_data = 1'b1;
      @(negedge clk);
    end
    wr_if.new_data = 1'b0;
    chk("full_busy", wr_if.busy, 1'b1);
    chk("full_tx_idle", tx, 1'b1);
    wr_if.data     = 8'h05;
    wr_if.new_data = 1'b1;
    @(negedge clk);
    wr_if.new_data = 1'b0;
    chk("ovf_pulse", wr_if.overflow, 1'b1);
    chk("ovf_busy", wr_if.busy, 1'b1);
    @(negedge clk);
    chk("ovf_one_cycle", wr_if.overflow, 1'b0);
    tick(20);
    chk("not_ready_hold", tx, 1'b1);
    ready = 1'b1;
    drain(5 * (FRAME + 2));

    // 3: tx_block raised mid-frame; frame completes, next byte waits for sync
    wr_if.data     = 8'h55;
    wr_if.new_data = 1'b1;
    @(negedge clk);
    wr_if.data = 8'h33;
    @(negedge clk);
    wr_if.new_data = 1'b0;
    tick(3 * CPB);
    tx_block = 1'b1;
    tick(FRAME + 300);
    chk("blk_hold", tx, 1'b1);
    tx_block = 1'b0;
    tick(3);
    chk("blk_release_high", tx, 1'b1);
    tick(1);
    chk("blk_release_low", tx, 1'b0);
    drain(2 * (FRAME + 2));

    // 4: ready drops during data bit 3; frame finishes and line stays idle
    wr_if.data     = 8'hC3;
    wr_if.new_data = 1'b1;
    @(negedge clk);
    wr_if.data = 8'h7E;
    @(negedge clk);
    wr_if.new_data = 1'b0;
    tick(455);
    ready = 1'b0;
    tick(FRAME);
    chk("ready_drop_idle", tx, 1'b1);
    tick(200);
    chk("ready_drop_idle_late", tx, 1'b1);
    ready = 1'b1;
    drain(2 * (FRAME + 2));

    // 5: full FIFO, pop and write in the same cycle -> write dropped
    ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wr_if.data     = 8'h10 + 8'(b);
      wr_if.new_data = 1'b1;
      @(negedge clk);
    end
    chk("fill2_busy", wr_if.busy, 1'b1);
    ready          = 1'b1;
    wr_if.data     = 8'hEE;
    wr_if.new_data = 1'b1;
    @(negedge clk);
    wr_if.new_data = 1'b0;
    chk("popwr_overflow", wr_if.overflow, 1'b1);
    chk("popwr_busy_clear", wr_if.busy, 1'b0);
    drain(5 * (FRAME + 2));

    // 6: asynchronous reset during DATA
    wr_if.data     = 8'h96;
    wr_if.new_data = 1'b1;
    @(negedge clk);
    wr_if.data = 8'h69;
    @(negedge clk);
    wr_if.data = 8'hF0;
    @(negedge clk);
    wr_if.new_data = 1'b0;
    tick(450);
    chk("pre_rst_bit3_low", tx, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_tx", tx, 1'b1);
    tick(2);
    rst = 1'b0;
    chk("post_rst_busy", wr_if.busy, 1'b0);
    tick(300);
    chk("fifo_discarded", tx, 1'b1);

    // randomized traffic with bursts, ready and tx_block toggling
    for (int c = 0; c < 12000; c++) begin
      @(negedge clk);
      wr_if.new_data = 1'b0;
      if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(1, 6);
      if (burst > 0) begin
        wr_if.new_data = 1'b1;
        wr_if.data     = 8'($urandom);
        burst--;
      end
      if ($urandom_range(0, 699) == 0) ready = ~ready;
      if ($urandom_range(0, 499) == 0) tx_block = ~tx_block;
    end
    @(negedge clk);
    wr_if.new_data = 1'b0;
    ready          = 1'b1;
    tx_block       = 1'b0;
    drain(6 * (FRAME + 2));
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
